// File: rtl/note_freq_pkg.sv
// Shared constants for the pitch-to-note stages: Q16.16 note tables for octave 4,
// normalization edges, note-name and state encodings.
package note_freq_pkg;

   localparam int FRAC_BITS = 16;

   typedef logic [31:0] q16_t;

   // Quarter-tone below C4 (254.1776 Hz); the octave window is [LOW_EDGE, 2*LOW_EDGE).
   localparam q16_t LOW_EDGE  = 32'd16657783;
   localparam q16_t HIGH_EDGE = LOW_EDGE << 1;

   localparam q16_t CENTER [0:11] = '{
      32'd17145893, 32'd18165441, 32'd19245614, 32'd20390018,
      32'd21602472, 32'd22887021, 32'd24247954, 32'd25689813,
      32'd27217409, 32'd28835840, 32'd30550508, 32'd32367136
   };

   localparam q16_t UPPER [0:11] = '{
      32'd17648306, 32'd18697729, 32'd19809554, 32'd20987491,
      32'd22235472, 32'd23557662, 32'd24958474, 32'd26442582,
      32'd28014940, 32'd29680795, 32'd31445706, 32'd33315566
   };

   typedef enum logic [3:0] {
      NOTE_C  = 4'd0,  NOTE_CS = 4'd1,  NOTE_D  = 4'd2,  NOTE_DS = 4'd3,
      NOTE_E  = 4'd4,  NOTE_F  = 4'd5,  NOTE_FS = 4'd6,  NOTE_G  = 4'd7,
      NOTE_GS = 4'd8,  NOTE_A  = 4'd9,  NOTE_AS = 4'd10, NOTE_B  = 4'd11
   } note_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_NORM = 2'd1,
      ST_SCAN = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // Re-express a Q16.16 table constant with fb fractional bits.
   function automatic q16_t rescale(input q16_t v, input int unsigned fb);
      if (fb >= FRAC_BITS) return v << (fb - FRAC_BITS);
      else                 return v >> (FRAC_BITS - fb);
   endfunction

endpackage

// File: rtl/note_edge_rom.sv
// Combinational lookup of a note's center and upper quarter-tone edge for octave 4.
module note_edge_rom
   import note_freq_pkg::*;
#(
   parameter int FRAC_BITS = 16
) (
   input  logic [3:0]  idx,
   output logic [31:0] center,
   output logic [31:0] upper
);

   always_comb begin
      center = '0;
      upper  = '0;
      for (int k = 0; k < 12; k++) begin
         if (idx == 4'(k)) begin
            center = rescale(CENTER[k], FRAC_BITS);
            upper  = rescale(UPPER[k], FRAC_BITS);
         end
      end
   end

endmodule

// File: rtl/freq_to_note.sv
// Iterative Q16.16 pitch to equal-tempered note converter: octave-normalize by
// shifting, then linearly scan the octave-4 edge table, one compare per cycle.
module freq_to_note
   import note_freq_pkg::*;
#(
   parameter int FRAC_BITS = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] freq_detected,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [3:0]  note_name,
   output logic [2:0]  note_octave,
   output logic        greater
);

   localparam logic [31:0] LOW_Q  = rescale(LOW_EDGE, FRAC_BITS);
   localparam logic [31:0] HIGH_Q = rescale(HIGH_EDGE, FRAC_BITS);

   state_e      state;
   logic [31:0] f;
   logic [2:0]  oct;
   logic [3:0]  idx;
   logic [31:0] center;
   logic [31:0] upper;

   note_edge_rom #(.FRAC_BITS(FRAC_BITS)) u_rom (
      .idx    (idx),
      .center (center),
      .upper  (upper)
   );

   assign busy = (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         f           <= '0;
         oct         <= '0;
         idx         <= '0;
         done        <= 1'b0;
         note_name   <= '0;
         note_octave <= '0;
         greater     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  f     <= freq_detected;
                  oct   <= 3'd4;
                  state <= ST_NORM;
               end
            end
            // Octave clamps at 0 and 7 make out-of-range inputs saturate to C0 / B7.
            ST_NORM: begin
               if (f < LOW_Q && oct != 3'd0) begin
                  f   <= f << 1;
                  oct <= oct - 3'd1;
               end else if (f >= HIGH_Q && oct != 3'd7) begin
                  f   <= f >> 1;
                  oct <= oct + 3'd1;
               end else begin
                  idx   <= '0;
                  state <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (f < upper || idx == 4'd11) begin
                  note_name   <= idx;
                  note_octave <= oct;
                  greater     <= (f > center);
                  done        <= 1'b1;
                  state       <= ST_DONE;
               end else begin
                  idx <= idx + 4'd1;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_freq_to_note.sv
// Scoreboard bench for freq_to_note: directed test-plan cases plus randomized
// requests checked against a real-arithmetic reference model.
module tb_freq_to_note;

   logic        clk;
   logic        reset;
   logic [31:0] freq;
   logic        start;
   logic        busy;
   logic        done;
   logic [3:0]  note_name;
   logic [2:0]  note_octave;
   logic        greater;

   freq_to_note #(.FRAC_BITS(16)) dut (
      .clk           (clk),
      .reset         (reset),
      .freq_detected (freq),
      .start         (start),
      .busy          (busy),
      .done          (done),
      .note_name     (note_name),
      .note_octave   (note_octave),
      .greater       (greater)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int     name;
      int     oct;
      int     gt;
      int     lat;
      longint due;
   } exp_t;

   exp_t   sb[$];
   exp_t   mon_e;
   int     total = 0;
   int     bad   = 0;
   longint cyc   = 0;
   longint ctr_t [12];
   longint upr_t [12];
   longint low_e;
   longint high_e;

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input longint got, input longint want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d (t=%0t)", nm, got, want, $time);
      end
   endtask

   task automatic flag(input string nm);
      total++;
      bad++;
      $display("FAIL %s (t=%0t)", nm, $time);
   endtask

   // Reference note tables straight from A4 = 440 Hz and 2^(1/24) steps.
   task automatic build_tables();
      for (int k = 0; k < 12; k++) begin
         ctr_t[k] = longint'(440.0 * (2.0 ** (real'(k - 9) / 12.0)) * 65536.0);
         upr_t[k] = longint'(440.0 * (2.0 ** (real'(2 * k - 17) / 24.0)) * 65536.0);
      end
      low_e  = longint'(440.0 * (2.0 ** (-19.0 / 24.0)) * 65536.0);
      high_e = 2 * low_e;
   endtask

   function automatic exp_t model(input logic [31:0] fin);
      exp_t   e;
      longint v = longint'(fin);
      int     o = 4;
      int     n = 0;
      int     i = 0;
      while (v < low_e && o > 0)   begin v = v * 2; o--; n++; end
      while (v >= high_e && o < 7) begin v = v / 2; o++; n++; end
      while (i < 11 && v >= upr_t[i]) i++;
      e.name = i;
      e.oct  = o;
      e.gt   = (v > ctr_t[i]) ? 1 : 0;
      e.lat  = n + i + 3;
      e.due  = 0;
      return e;
   endfunction

   function automatic exp_t mk(input int nm, input int o, input int g, input int l);
      exp_t e;
      e.name = nm; e.oct = o; e.gt = g; e.lat = l; e.due = 0;
      return e;
   endfunction

   // Called at a negedge; returns one negedge after the start pulse.
   task automatic issue(input logic [31:0] fv, input exp_t e, input bit track,
                        output longint at);
      int w = 0;
      while (busy && w < 100) begin @(negedge clk); w++; end
      if (busy) flag("busy_timeout");
      at    = cyc;
      freq  = fv;
      start = 1'b1;
      e.due = cyc + e.lat;
      if (track) sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done();
      int w = 0;
      while (done !== 1'b1 && w < 40) begin @(negedge clk); w++; end
      if (done !== 1'b1) flag("done_timeout");
   endtask

   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            flag("spurious_done");
         end else begin
            mon_e = sb.pop_front();
            chk("note_name",   longint'(note_name),   longint'(mon_e.name));
            chk("note_octave", longint'(note_octave), longint'(mon_e.oct));
            chk("greater",     longint'(greater),     longint'(mon_e.gt));
            chk("done_cycle",  cyc,                   mon_e.due);
         end
      end
   end

   initial begin
      longint at;
      longint prev_due;
      logic [31:0] fv;
      logic [31:0] base;
      int          kind;
      int          sh;
      int          w;

      build_tables();
      reset = 1'b1;
      start = 1'b0;
      freq  = '0;
      repeat (3) @(negedge clk);
      chk("rst_done",   longint'(done),        0);
      chk("rst_busy",   longint'(busy),        0);
      chk("rst_name",   longint'(note_name),   0);
      chk("rst_octave", longint'(note_octave), 0);
      chk("rst_greater",longint'(greater),     0);
      reset = 1'b0;
      @(negedge clk);

      // Test-plan cases with hand-derived expectations.
      issue(32'd19245302,   mk(2, 4, 0, 5),   1, at);   // D4 293.66 Hz
      issue(32'd7208960,    mk(9, 2, 0, 14),  1, at);   // A2 110 Hz
      issue(32'd29163520,   mk(9, 4, 1, 12),  1, at);   // 445 Hz
      issue(32'd28508160,   mk(9, 4, 0, 12),  1, at);   // 435 Hz
      issue(32'd28835840,   mk(9, 4, 0, 12),  1, at);   // exact A4 center
      issue(32'd0,          mk(0, 0, 0, 7),   1, at);   // 0 Hz -> C0
      issue(32'd2621440000, mk(11, 7, 1, 17), 1, at);   // 40 kHz -> B7
      prev_due = sb[sb.size() - 1].due;

      // Next start must land in the cycle right after done.
      issue(32'd19245302, mk(2, 4, 0, 5), 1, at);
      chk("b2b_accept_cycle", at, prev_due + 1);

      // Starts while busy and in the done cycle are both ignored.
      freq  = 32'd2621440000;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done();
      freq  = 32'd7208960;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("ignore_done_start_busy", longint'(busy), 0);
      repeat (3) @(negedge clk);
      chk("hold_name",   longint'(note_name),   2);
      chk("hold_octave", longint'(note_octave), 4);
      chk("hold_greater",longint'(greater),     0);
      chk("hold_idle",   longint'(busy),        0);

      // Reset during SCAN aborts without a done pulse.
      issue(32'd7208960, mk(9, 2, 0, 14), 0, at);
      repeat (5) @(negedge clk);
      chk("midop_busy", longint'(busy), 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_busy",   longint'(busy),        0);
      chk("abort_done",   longint'(done),        0);
      chk("abort_name",   longint'(note_name),   0);
      chk("abort_octave", longint'(note_octave), 0);
      chk("abort_greater",longint'(greater),     0);
      repeat (20) @(negedge clk);
      issue(32'd7208960, mk(9, 2, 0, 14), 1, at);

      // Randomized requests spread across all octaves plus raw 32-bit values.
      for (int r = 0; r < 150; r++) begin
         kind = int'($urandom_range(0, 7));
         base = $urandom_range(32'd16657783, 32'd33315565);
         sh   = int'($urandom_range(0, 7));
         if (kind == 0)      fv = $urandom;
         else if (kind == 1) fv = $urandom_range(0, 400);
         else if (sh < 4)    fv = base >> (4 - sh);
         else                fv = base << (sh - 4);
         issue(fv, model(fv), 1, at);
      end

      w = 0;
      while (sb.size() != 0 && w < 100) begin @(negedge clk); w++; end
      if (sb.size() != 0) flag("drain_timeout");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
